// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, opcode constants and fetch state type
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  localparam logic [3:0] OP_LDPC = 4'hF;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_INC  = 4'h5;
  localparam logic [3:0] OP_NEG  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_BRZ  = 4'h9;
  localparam logic [3:0] OP_JM   = 4'hA;
  localparam logic [3:0] OP_BRN  = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC select: redirect, advance or hold
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            advance,
  output logic [PC_W-1:0] pc_nxt
);

  always_comb begin
    pc_nxt = pc;
    if (br_taken) begin
      pc_nxt = br_target;
    end else if (advance) begin
      pc_nxt = pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, redirect flush and halt
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] LAST_PC  = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               advance;

  pc_next u_pc_next (
    .pc        (pc_q),
    .br_taken  (br_taken),
    .br_target (br_target),
    .advance   (advance),
    .pc_nxt    (pc_d)
  );

  // Redirect beats stall; the word on imem_data belongs to the wrong path and is dropped.
  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    advance      = 1'b0;
    if (br_taken) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b0;
      state_d      = RUN;
    end else if (!stall) begin
      if (state_q == RUN) begin
        ifid_instr_d = imem_data;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        if (pc_q == LAST_PC) begin
          state_d = HALT;
        end else begin
          advance = 1'b1;
        end
      end else begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural fetch model
module tb_fetch_stage;

  localparam logic [7:0] LAST = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = 32'h0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h0;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [256];

  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  logic        m_halt;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.RESET_PC(8'h00), .LAST_PC(LAST)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) imem_data = mem[imem_addr];

  // One clock: drive inputs, let the edge happen, update the model from the rules.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [7:0] t);
    rst = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk);
    if (r) begin
      m_pc = 8'h00; m_instr = 32'h0; m_ipc = 8'h00; m_valid = 1'b0; m_halt = 1'b0;
    end else if (b) begin
      m_ipc = m_pc; m_instr = 32'h0; m_valid = 1'b0; m_pc = t; m_halt = 1'b0;
    end else if (s) begin
      m_pc = m_pc;
    end else if (!m_halt) begin
      m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
      if (m_pc == LAST) m_halt = 1'b1;
      else m_pc = m_pc + 8'd1;
    end else begin
      m_instr = 32'h0; m_ipc = m_pc; m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", imem_addr); end
    n_tests++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    n_tests++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", ifid_instr); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_tests++; if (ifid_pc !== 8'h00) begin n_fail++; $display("FAIL reset_ifid_pc got %h want 00", ifid_pc); end
    cycle(0, 0, 0, 0);
    n_tests++; if (ifid_instr !== 32'hF04000FF || ifid_pc !== 8'h00 || ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch got %h/%h/%b want f04000ff/00/1", ifid_instr, ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      n_tests++; if (ifid_pc !== 8'(i) || ifid_valid !== 1'b1 || ifid_instr !== mem[i]) begin
        n_fail++; $display("FAIL seq_%0d got pc %h v %b i %h want pc %h v 1 i %h", i, ifid_pc, ifid_valid, ifid_instr, 8'(i), mem[i]);
      end
    end
    n_tests++; if (imem_addr !== 8'h05) begin n_fail++; $display("FAIL seq_end_addr got %h want 05", imem_addr); end
  endtask

  task automatic test_stall();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0);
      n_tests++; if (imem_addr !== 8'h03 || ifid_pc !== 8'h02 || ifid_instr !== mem[2] || ifid_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold_%0d got a %h pc %h i %h want a 03 pc 02 i %h", i, imem_addr, ifid_pc, ifid_instr, mem[2]);
      end
    end
    cycle(0, 0, 0, 0);
    n_tests++; if (ifid_pc !== 8'h03 || ifid_instr !== mem[3] || imem_addr !== 8'h04) begin
      n_fail++; $display("FAIL stall_resume got pc %h i %h a %h want 03 %h 04", ifid_pc, ifid_instr, imem_addr, mem[3]);
    end
  endtask

  task automatic test_branch();
    while (m_pc != 8'h09) cycle(0, 0, 0, 0);
    n_tests++; if (imem_addr !== 8'h09) begin n_fail++; $display("FAIL br_pre_addr got %h want 09", imem_addr); end
    cycle(0, 1, 1, 8'h0D);
    n_tests++; if (ifid_valid !== 1'b0 || imem_addr !== 8'h0D || ifid_instr !== 32'h0 || ifid_pc !== 8'h09) begin
      n_fail++; $display("FAIL br_bubble got v %b a %h i %h pc %h want 0 0d 0 09", ifid_valid, imem_addr, ifid_instr, ifid_pc);
    end
    cycle(0, 0, 0, 0);
    n_tests++; if (ifid_instr !== 32'h30010400 || ifid_pc !== 8'h0D || ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL br_target_fetch got %h/%h/%b want 30010400/0d/1", ifid_instr, ifid_pc, ifid_valid);
    end
  endtask

  task automatic test_halt();
    int budget = 100;
    while (!(ifid_valid === 1'b1 && ifid_pc === LAST) && budget > 0) begin
      cycle(0, 0, 0, 0);
      budget--;
    end
    n_tests++; if (budget == 0) begin n_fail++; $display("FAIL halt_reach got pc %h want %h within budget", ifid_pc, LAST); end
    n_tests++; if (halted !== 1'b1 || imem_addr !== LAST || ifid_instr !== mem[LAST]) begin
      n_fail++; $display("FAIL halt_enter got h %b a %h i %h want 1 20 %h", halted, imem_addr, ifid_instr, mem[LAST]);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0);
      n_tests++; if (ifid_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== LAST || ifid_instr !== 32'h0) begin
        n_fail++; $display("FAIL halt_idle_%0d got v %b h %b a %h i %h want 0 1 20 0", i, ifid_valid, halted, imem_addr, ifid_instr);
      end
    end
    cycle(0, 0, 1, 8'h05);
    n_tests++; if (halted !== 1'b0 || imem_addr !== 8'h05 || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_exit got h %b a %h v %b want 0 05 0", halted, imem_addr, ifid_valid);
    end
    cycle(0, 0, 0, 0);
    n_tests++; if (ifid_pc !== 8'h05 || ifid_valid !== 1'b1 || ifid_instr !== mem[5]) begin
      n_fail++; $display("FAIL halt_resume got pc %h v %b i %h want 05 1 %h", ifid_pc, ifid_valid, ifid_instr, mem[5]);
    end
  endtask

  task automatic test_reset_special();
    cycle(0, 0, 1, 8'h1F);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL rsth_pre got halted %b want 1", halted); end
    cycle(1, 0, 0, 0);
    n_tests++; if (imem_addr !== 8'h00 || ifid_instr !== 32'h0 || ifid_pc !== 8'h00 || ifid_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_halt got a %h i %h pc %h v %b h %b want all reset", imem_addr, ifid_instr, ifid_pc, ifid_valid, halted);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    n_tests++; if (imem_addr !== 8'h00 || ifid_instr !== 32'h0 || ifid_pc !== 8'h00 || ifid_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_stall got a %h i %h pc %h v %b h %b want all reset", imem_addr, ifid_instr, ifid_pc, ifid_valid, halted);
    end
    cycle(1, 0, 1, 8'h44);
    n_tests++; if (imem_addr !== 8'h00 || ifid_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_over_br got a %h v %b want 00 0", imem_addr, ifid_valid);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    logic r, s, b;
    logic [7:0] t;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      b = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 3))
        0: t = LAST - 8'($urandom_range(0, 3));
        1: t = m_pc;
        2: t = 8'($urandom_range(0, 31));
        default: t = 8'($urandom);
      endcase
      cycle(r, s, b, t);
      n_tests++;
      if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc !== m_ipc ||
          ifid_valid !== m_valid || halted !== m_halt) begin
        n_fail++;
        if (errs < 10) $display("FAIL rand_%0d got a %h i %h pc %h v %b h %b want a %h i %h pc %h v %b h %b",
          i, imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, m_pc, m_instr, m_ipc, m_valid, m_halt);
        errs++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h00] = 32'hF04000FF;
    mem[8'h0D] = 32'h30010400;
    m_pc = 8'h00; m_instr = 32'h0; m_ipc = 8'h00; m_valid = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_reset_special();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
